// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora TX path: AXI-stream lane widths and the
// state encoding of the packet arbiter.
package aurora_pkg;

    localparam int AXIS_DW = 32;
    localparam int AXIS_KW = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_PASS = 1'b1
    } arb_state_t;

endpackage

// File: rtl/aurora_axi_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Searches req starting at last+1, wrapping modulo N, and returns the first
// set index.
//   req   : request vector
//   last  : index granted most recently
//   idx   : chosen index (0 when found=0)
//   found : at least one request set
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] idx,
    output logic          found
);

    logic [LW-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = LW'((int'(last) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/aurora_axi_tx_arb.sv
// aurora_axi_tx_arb: packet-granular round-robin arbiter that time-multiplexes
// ETHCOUNT AXI-stream sources onto the single Aurora TX lane. A granted source
// owns the lane until it sends tlast or its watchdog expires.
//   clk, rstn                 : clock, asynchronous active-low reset
//   eth_mask                  : 1 = channel never granted
//   axis_s_*                  : packed per-source AXIS slave ports (32b data)
//   axis_m_*                  : registered AXIS master port toward Aurora TX
//   arb_grant                 : one-hot current grant, 0 while idle
//   err_timeout               : 1-cycle pulse when a stalled grant is revoked
//
// state    | meaning
// ARB_IDLE | no owner; pick next requester round-robin from last_grant+1
// ARB_PASS | granted source forwards beats until tlast or watchdog expiry
module aurora_axi_tx_arb
    import aurora_pkg::*;
#(
    parameter int ETHCOUNT = 4,
    parameter int TIMEOUT  = 1024,
    parameter int SIM      = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [ETHCOUNT-1:0]         eth_mask,
    output logic [ETHCOUNT-1:0]         axis_s_tready,
    input  logic [ETHCOUNT*AXIS_DW-1:0] axis_s_tdata,
    input  logic [ETHCOUNT*AXIS_KW-1:0] axis_s_tkeep,
    input  logic [ETHCOUNT-1:0]         axis_s_tvalid,
    input  logic [ETHCOUNT-1:0]         axis_s_tlast,
    input  logic                        axis_m_tready,
    output logic [AXIS_DW-1:0]          axis_m_tdata,
    output logic [AXIS_KW-1:0]          axis_m_tkeep,
    output logic                        axis_m_tvalid,
    output logic                        axis_m_tlast,
    output logic [ETHCOUNT-1:0]         arb_grant,
    output logic                        err_timeout
);

    localparam int LW = (ETHCOUNT > 1) ? $clog2(ETHCOUNT) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]       WD_LAST   = CW'(TIMEOUT - 1);
    localparam logic [LW-1:0]       LAST_RST  = LW'(ETHCOUNT - 1);
    localparam logic [ETHCOUNT-1:0] GRANT_ONE = ETHCOUNT'(1);

    arb_state_t          state_q, state_d;
    logic [LW-1:0]       g_q;
    logic [LW-1:0]       last_q;
    logic [ETHCOUNT-1:0] grant_q;
    logic [CW-1:0]       wd_q;
    logic                err_q;

    logic [ETHCOUNT-1:0] req;
    logic [LW-1:0]       pick_idx;
    logic                pick_found;
    logic                g_valid, g_last, tready_g, hs, expire, pkt_end;
    logic [AXIS_DW-1:0]  g_data;
    logic [AXIS_KW-1:0]  g_keep;

    rr_pick #(.N(ETHCOUNT), .LW(LW)) u_pick (
        .req   (req),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        req      = axis_s_tvalid & ~eth_mask;
        g_valid  = axis_s_tvalid[g_q];
        g_last   = axis_s_tlast[g_q];
        g_data   = axis_s_tdata[int'(g_q)*AXIS_DW +: AXIS_DW];
        g_keep   = axis_s_tkeep[int'(g_q)*AXIS_KW +: AXIS_KW];
        // The output register can take a beat when empty or draining this cycle.
        tready_g = (state_q == ARB_PASS) & (~axis_m_tvalid | axis_m_tready);
        hs       = tready_g & g_valid;
        pkt_end  = hs & g_last;
        // Expiry needs tvalid low, so it can never coincide with a handshake;
        // a tlast beat always wins.
        expire   = (state_q == ARB_PASS) & ~g_valid & (wd_q == WD_LAST);
        axis_s_tready = tready_g ? grant_q : '0;

        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (pick_found) state_d = ARB_PASS;
            ARB_PASS: if (pkt_end || expire) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            g_q           <= '0;
            last_q        <= LAST_RST;
            grant_q       <= '0;
            wd_q          <= '0;
            err_q         <= 1'b0;
            axis_m_tdata  <= '0;
            axis_m_tkeep  <= '0;
            axis_m_tlast  <= 1'b0;
            axis_m_tvalid <= 1'b0;
        end else begin
            err_q <= expire & ~pkt_end;
            if (state_q == ARB_IDLE) begin
                wd_q <= '0;
                if (pick_found) begin
                    grant_q <= GRANT_ONE << pick_idx;
                    g_q     <= pick_idx;
                end
            end else begin
                if (hs)
                    wd_q <= '0;
                else if (!g_valid && wd_q != WD_LAST)
                    wd_q <= wd_q + 1'b1;
                if (pkt_end || expire) begin
                    last_q  <= g_q;
                    grant_q <= '0;
                end
            end

            if (hs) begin
                axis_m_tdata  <= g_data;
                axis_m_tkeep  <= g_keep;
                axis_m_tlast  <= g_last;
                axis_m_tvalid <= 1'b1;
            end else if (axis_m_tready) begin
                axis_m_tvalid <= 1'b0;
            end
        end
    end

    assign arb_grant   = grant_q;
    assign err_timeout = err_q;

    generate
        if (SIM != 0) begin : g_sim_chk
            a_tready_onehot: assert property (@(posedge clk) disable iff (!rstn)
                $onehot0(axis_s_tready));
            a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn)
                $onehot0(arb_grant));
        end
    endgenerate

endmodule
